foo_pipeline_arbiter: RTL and testbench
=======================================

// Module: foo_pipeline_arbiter
//
// PURPOSE
//   Shares one instance of the pipelined "foo" datapath (out = x + 1, valid-in/valid-out,
//   no stall) between NUM_REQ requesters.
//   - Round-robin arbitration issues at most one operand per cycle into the pipeline.
//   - A tag shift register follows each operand through the pipeline.
//   - Each result is routed back to the requester that issued it.
//   - An enable/drain FSM allows clean quiescing of the shared pipeline.
//
// PARAMETERS
//   NUM_REQ   4   number of requesters (2..16)
//   DATA_W    32  operand/result width; must match the foo pipeline
//   PIPE_LAT  1   cycles from pipe_input_valid to pipe_output_valid (>=1)
//
// PORTS
//   clk               in   1                clock
//   rst               in   1                async reset, active-high
//   enable            in   1                1 = accept requests; 0 = drain then idle
//   req_valid         in   NUM_REQ          per-requester request valid
//   req_ready         out  NUM_REQ          per-requester ready (one-hot or zero)
//   req_data          in   NUM_REQ*DATA_W   operands, requester i at [i*DATA_W +: DATA_W]
//   resp_valid        out  NUM_REQ          one-hot result strobe; no backpressure
//   resp_data         out  DATA_W           result, broadcast to all requesters
//   pipe_x            out  DATA_W           to foo.x
//   pipe_input_valid  out  1                to foo.input_valid
//   pipe_out          in   DATA_W           from foo.out
//   pipe_output_valid in   1                from foo.output_valid
//   busy              out  1                state != IDLE
//   tag_err           out  1                sticky: pipe_output_valid != tag valid at pipe exit
//
// BEHAVIOUR
//   FSM (state register, async reset to IDLE):
//   - IDLE:  no grants. Goes to RUN when enable=1.
//   - RUN:   grants allowed.
//            enable=0 and inflight!=0 -> DRAIN.
//            enable=0 and inflight==0 -> IDLE.
//   - DRAIN: no grants; enable is ignored.
//            -> IDLE when inflight==0.
//   Arbitration (RUN only, combinational from req_valid and ptr):
//   - Search starts at index ptr, wrapping modulo NUM_REQ. The first valid requester g gets req_ready[g]=1.
//   - Transfer occurs when req_valid[g] & req_ready[g]:
//       pipe_input_valid=1, pipe_x=req_data[g], ptr <= (g+1) mod NUM_REQ.
//   - No transfer: ptr holds, pipe_input_valid=0, pipe_x=0.
//   - req_ready is never asserted without the matching req_valid.
//   Tag pipeline:
//   - PIPE_LAT stages of {vld, id[$clog2(NUM_REQ)-1:0]}, shifted every cycle.
//   - Stage 0 is loaded with {transfer, g}.
//   - At the exit stage: resp_valid[id] = vld & pipe_output_valid; resp_data = pipe_out.
//   - tag_err is set when vld != pipe_output_valid and cleared only by rst.
//   inflight counter (0..PIPE_LAT):
//   - +1 on transfer, -1 on exit vld; both in one cycle leaves it unchanged.
//   - Saturation is unreachable by construction; assert it in simulation.
//   Latency: request handshake at edge N -> resp_valid high during cycle N+PIPE_LAT.
//   Full throughput: one request per cycle, back-to-back, any mix of requesters.
//   Reset:
//   - rst asserts asynchronously: state=IDLE, ptr=0, tags cleared, inflight=0, tag_err=0.
//   - All outputs then read 0: req_ready, resp_valid, resp_data, pipe_x, pipe_input_valid, busy.
//   - Reset mid-operation discards in-flight results; no resp_valid follows.
//   - rst is also wired to the foo pipeline (its sync valid clear is covered by the tag clear).
//   Single requester valid continuously: granted every cycle; ptr wraps to (g+1) mod NUM_REQ.
//
// CONFIGURATION
//   FOO_PIPELINE_ARBITER_STATS_EN
//   - Defined: adds output grant_count [NUM_REQ*16], a 16-bit counter per requester.
//     Each counter increments on that requester's transfer and saturates at 16'hFFFF.
//     The counters reset asynchronously to 0.
//   - Undefined: the port and the counters are absent; all other behaviour is identical.
//
// TESTING
//   1. Reset, enable=1, req_valid=4'b0001, data0=32'h0000_0005
//      -> pipe_x=5 in the same cycle; resp_valid=4'b0001, resp_data=6 one cycle later.
//   2. req_valid=4'b1111 held 8 cycles
//      -> grants 0,1,2,3,0,1,2,3 with no bubbles; resp ids in the same order, each data+1.
//   3. req_valid=4'b0101 from ptr=0
//      -> grants alternate 0,2,0,2; requesters 1 and 3 never get req_ready.
//   4. data=32'hFFFF_FFFF
//      -> resp_data=32'h0000_0000 (wrap-around), no error.
//   5. Drain: issue req3, drop enable in the same cycle -> state DRAIN, busy=1, no new grants;
//      resp_valid[3] arrives, then IDLE, busy=0. Re-raise enable -> RUN on the next edge.
//   6. rst pulsed mid-stream with inflight=1 -> all outputs 0 immediately; no resp_valid after
//      release; tag_err stays 0. With STATS_EN, counters read 0.

Source files
------------

// File: rtl/foo_pipeline_arbiter_if.sv
// Requester-side bus of foo_pipeline_arbiter: per-requester request handshake plus broadcast result.
// master = requester side, slave = arbiter side.
interface foo_pipeline_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [DATA_W-1:0]         resp_data;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready,
        input  resp_valid,
        input  resp_data
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready,
        output resp_valid,
        output resp_data
    );
endinterface

// File: rtl/foo_pipeline_arbiter.sv
// Round-robin sharing of one no-stall foo pipeline between NUM_REQ requesters, with tag tracking and drain FSM.
// Optional per-requester grant counters when FOO_PIPELINE_ARBITER_STATS_EN is defined.
module foo_pipeline_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned PIPE_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable_i,
    foo_pipeline_arbiter_if.slave    req_if,
    output logic [DATA_W-1:0]        pipe_x_o,
    output logic                     pipe_input_valid_o,
    input  logic [DATA_W-1:0]        pipe_out_i,
    input  logic                     pipe_output_valid_i,
    output logic                     busy_o,
    output logic                     tag_err_o
`ifdef FOO_PIPELINE_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]    grant_count_o
`endif
);
    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(PIPE_LAT + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

    logic [1:0]                state_q, state_d;
    logic [ID_W-1:0]           ptr_q, ptr_d;
    tag_t [PIPE_LAT-1:0]       tag_q, tag_d;
    logic [CNT_W-1:0]          inflight_q, inflight_d;
    logic                      tag_err_q, tag_err_d;

    logic                      found;
    logic [ID_W-1:0]           gnt_id;
    logic                      transfer;
    int unsigned               idx;
    tag_t                      exit_tag;
    logic                      resp_fire;
    logic [NUM_REQ-1:0]        req_ready;

    // Round-robin search starting at ptr_q, wrapping modulo NUM_REQ.
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        idx    = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_if.req_valid[ID_W'(idx)]) begin
                found  = 1'b1;
                gnt_id = ID_W'(idx);
            end
        end
    end

    assign transfer  = (state_q == RUN) && found;
    assign req_ready = transfer ? (NUM_REQ'(1) << gnt_id) : '0;
    assign req_if.req_ready = req_ready;

    assign pipe_input_valid_o = transfer;
    assign pipe_x_o           = transfer ? req_if.req_data[gnt_id*DATA_W +: DATA_W] : '0;

    // Results are steered by the tag that left the pipe alongside them.
    assign exit_tag  = tag_q[PIPE_LAT-1];
    assign resp_fire = exit_tag.vld && pipe_output_valid_i;
    assign req_if.resp_valid = resp_fire ? (NUM_REQ'(1) << exit_tag.id) : '0;
    assign req_if.resp_data  = resp_fire ? pipe_out_i : '0;

    assign busy_o    = (state_q != IDLE);
    assign tag_err_o = tag_err_q;

    always_comb begin
        ptr_d      = ptr_q;
        tag_d      = tag_q;
        inflight_d = inflight_q;
        tag_err_d  = tag_err_q | (exit_tag.vld != pipe_output_valid_i);
        if (transfer) begin
            ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
        end
        tag_d[0].vld = transfer;
        tag_d[0].id  = gnt_id;
        for (int unsigned i = 1; i < PIPE_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        if (transfer && !exit_tag.vld) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!transfer && exit_tag.vld) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    // A grant issued in the cycle enable drops still counts as in flight.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!enable_i) begin
                    state_d = ((inflight_q != '0) || transfer) ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (inflight_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            tag_q      <= '0;
            inflight_q <= '0;
            tag_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            tag_err_q  <= tag_err_d;
        end
    end

    ap_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(transfer && !exit_tag.vld && (inflight_q == CNT_W'(PIPE_LAT))));
    ap_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(exit_tag.vld && !transfer && (inflight_q == '0)));

`ifdef FOO_PIPELINE_ARBITER_STATS_EN
    logic [NUM_REQ-1:0][15:0] gcnt_q, gcnt_d;

    // Saturating per-requester grant counters.
    always_comb begin
        gcnt_d = gcnt_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i] && req_if.req_valid[i] && (gcnt_q[i] != 16'hFFFF)) begin
                gcnt_d[i] = gcnt_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gcnt_q <= '0;
        end else begin
            gcnt_q <= gcnt_d;
        end
    end

    assign grant_count_o = gcnt_q;
`endif

endmodule

// File: tb/tb_foo_pipeline_arbiter.sv
// Directed table-driven bench for foo_pipeline_arbiter with a one-stage foo (x + 1) model.
module tb_foo_pipeline_arbiter;
    localparam int unsigned NR = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned PL = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [DW-1:0] pipe_x;
    logic          pipe_input_valid;
    logic [DW-1:0] pipe_out;
    logic          pipe_output_valid;
    logic          busy;
    logic          tag_err;
`ifdef FOO_PIPELINE_ARBITER_STATS_EN
    logic [NR*16-1:0] grant_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    foo_pipeline_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

    foo_pipeline_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .PIPE_LAT(PL)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .enable_i            (enable),
        .req_if              (bus.slave),
        .pipe_x_o            (pipe_x),
        .pipe_input_valid_o  (pipe_input_valid),
        .pipe_out_i          (pipe_out),
        .pipe_output_valid_i (pipe_output_valid),
        .busy_o              (busy),
        .tag_err_o           (tag_err)
`ifdef FOO_PIPELINE_ARBITER_STATS_EN
        ,
        .grant_count_o       (grant_count)
`endif
    );

    // Reference foo pipeline: out = x + 1, synchronous valid clear on rst.
    logic [DW-1:0] m_x [PL];
    logic          m_v [PL];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PL; i++) m_v[i] <= 1'b0;
        end else begin
            m_v[0] <= pipe_input_valid;
            for (int i = 1; i < PL; i++) m_v[i] <= m_v[i-1];
        end
        m_x[0] <= pipe_x + 32'd1;
        for (int i = 1; i < PL; i++) m_x[i] <= m_x[i-1];
    end
    assign pipe_out          = m_x[PL-1];
    assign pipe_output_valid = m_v[PL-1];

    typedef struct {
        logic        en;
        logic [3:0]  rv;
        logic [31:0] d0, d1, d2, d3;
        logic [3:0]  ready;
        logic        piv;
        logic [31:0] px;
        logic [3:0]  resp;
        logic [31:0] rdata;
        logic        busy;
    } vec_t;

    vec_t vt [20];

    function automatic vec_t mk(logic en, logic [3:0] rv, logic [31:0] d0, logic [31:0] d1,
                                logic [31:0] d2, logic [31:0] d3, logic [3:0] ready, logic piv,
                                logic [31:0] px, logic [3:0] resp, logic [31:0] rdata, logic bsy);
        vec_t v;
        v.en = en; v.rv = rv; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3;
        v.ready = ready; v.piv = piv; v.px = px; v.resp = resp; v.rdata = rdata; v.busy = bsy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [3:0] rv, input logic [31:0] d0,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3);
        enable        = en;
        bus.req_valid = rv;
        bus.req_data  = {d3, d2, d1, d0};
    endtask

    task automatic check_outs(input string tag, input logic [3:0] ready, input logic piv,
                              input logic [31:0] px, input logic [3:0] resp,
                              input logic [31:0] rdata, input logic bsy);
        chk({tag, " req_ready"},        32'(bus.req_ready),  32'(ready));
        chk({tag, " pipe_input_valid"}, 32'(pipe_input_valid), 32'(piv));
        chk({tag, " pipe_x"},           pipe_x,              px);
        chk({tag, " resp_valid"},       32'(bus.resp_valid), 32'(resp));
        chk({tag, " resp_data"},        bus.resp_data,       rdata);
        chk({tag, " busy"},             32'(busy),           32'(bsy));
        chk({tag, " tag_err"},          32'(tag_err),        32'(0));
    endtask

    initial begin
        // Test 1 (v0-v2), test 2 (v3-v10), test 3 (v11-v14), test 4 and single-requester streak (v15-v19).
        vt[0]  = mk(1, 4'b0001, 32'h5,  32'h20, 32'h30, 32'h40, 4'b0000, 0, 32'h0,  4'b0000, 32'h0, 0);
        vt[1]  = mk(1, 4'b0001, 32'h5,  32'h20, 32'h30, 32'h40, 4'b0001, 1, 32'h5,  4'b0000, 32'h0, 1);
        vt[2]  = mk(1, 4'b1000, 32'h10, 32'h20, 32'h30, 32'h40, 4'b1000, 1, 32'h40, 4'b0001, 32'h6, 1);
        vt[3]  = mk(1, 4'b1111, 32'h10, 32'h20, 32'h30, 32'h40, 4'b0001, 1, 32'h10, 4'b1000, 32'h41, 1);
        vt[4]  = mk(1, 4'b1111, 32'h10, 32'h20, 32'h30, 32'h40, 4'b0010, 1, 32'h20, 4'b0001, 32'h11, 1);
        vt[5]  = mk(1, 4'b1111, 32'h10, 32'h20, 32'h30, 32'h40, 4'b0100, 1, 32'h30, 4'b0010, 32'h21, 1);
        vt[6]  = mk(1, 4'b1111, 32'h10, 32'h20, 32'h30, 32'h40, 4'b1000, 1, 32'h40, 4'b0100, 32'h31, 1);
        vt[7]  = mk(1, 4'b1111, 32'h10, 32'h20, 32'h30, 32'h40, 4'b0001, 1, 32'h10, 4'b1000, 32'h41, 1);
        vt[8]  = mk(1, 4'b1111, 32'h10, 32'h20, 32'h30, 32'h40, 4'b0010, 1, 32'h20, 4'b0001, 32'h11, 1);
        vt[9]  = mk(1, 4'b1111, 32'h10, 32'h20, 32'h30, 32'h40, 4'b0100, 1, 32'h30, 4'b0010, 32'h21, 1);
        vt[10] = mk(1, 4'b1111, 32'h10, 32'h20, 32'h30, 32'h40, 4'b1000, 1, 32'h40, 4'b0100, 32'h31, 1);
        vt[11] = mk(1, 4'b0101, 32'h10, 32'h20, 32'h30, 32'h40, 4'b0001, 1, 32'h10, 4'b1000, 32'h41, 1);
        vt[12] = mk(1, 4'b0101, 32'h10, 32'h20, 32'h30, 32'h40, 4'b0100, 1, 32'h30, 4'b0001, 32'h11, 1);
        vt[13] = mk(1, 4'b0101, 32'h10, 32'h20, 32'h30, 32'h40, 4'b0001, 1, 32'h10, 4'b0100, 32'h31, 1);
        vt[14] = mk(1, 4'b0101, 32'h10, 32'h20, 32'h30, 32'h40, 4'b0100, 1, 32'h30, 4'b0001, 32'h11, 1);
        vt[15] = mk(1, 4'b0001, 32'hFFFF_FFFF, 32'h20, 32'h30, 32'h40, 4'b0001, 1, 32'hFFFF_FFFF, 4'b0100, 32'h31, 1);
        vt[16] = mk(1, 4'b0000, 32'hFFFF_FFFF, 32'h20, 32'h30, 32'h40, 4'b0000, 0, 32'h0, 4'b0001, 32'h0, 1);
        vt[17] = mk(1, 4'b0001, 32'h7FFF_FFFF, 32'h20, 32'h30, 32'h40, 4'b0001, 1, 32'h7FFF_FFFF, 4'b0000, 32'h0, 1);
        vt[18] = mk(1, 4'b0001, 32'h7FFF_FFFF, 32'h20, 32'h30, 32'h40, 4'b0001, 1, 32'h7FFF_FFFF, 4'b0001, 32'h8000_0000, 1);
        vt[19] = mk(1, 4'b0000, 32'h7FFF_FFFF, 32'h20, 32'h30, 32'h40, 4'b0000, 0, 32'h0, 4'b0001, 32'h8000_0000, 1);

        rst = 1'b1;
        drive(0, 4'b0000, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1 check_outs("reset", 4'b0000, 0, 32'h0, 4'b0000, 32'h0, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            drive(vt[i].en, vt[i].rv, vt[i].d0, vt[i].d1, vt[i].d2, vt[i].d3);
            #1 check_outs($sformatf("v%0d", i), vt[i].ready, vt[i].piv, vt[i].px,
                          vt[i].resp, vt[i].rdata, vt[i].busy);
            @(negedge clk);
        end

        // Drain: grant req3 while enable drops, result still delivered, then IDLE.
        drive(0, 4'b1000, 32'h10, 32'h20, 32'h30, 32'h55);
        #1 check_outs("drain_issue", 4'b1000, 1, 32'h55, 4'b0000, 32'h0, 1);
        @(negedge clk);
        drive(0, 4'b1111, 32'h10, 32'h20, 32'h30, 32'h55);
        #1 check_outs("drain_resp", 4'b0000, 0, 32'h0, 4'b1000, 32'h56, 1);
        @(negedge clk);
        drive(1, 4'b1111, 32'h10, 32'h20, 32'h30, 32'h55);
        #1 check_outs("drain_ignore_en", 4'b0000, 0, 32'h0, 4'b0000, 32'h0, 1);
        @(negedge clk);
        #1 check_outs("drain_idle", 4'b0000, 0, 32'h0, 4'b0000, 32'h0, 0);
        @(negedge clk);
        drive(1, 4'b0001, 32'h10, 32'h20, 32'h30, 32'h55);
        #1 check_outs("rerun", 4'b0001, 1, 32'h10, 4'b0000, 32'h0, 1);
        @(negedge clk);

        // Reset with one result in flight.
`ifdef FOO_PIPELINE_ARBITER_STATS_EN
        chk("grant_count0 pre", 32'(grant_count[0  +: 16]), 32'd9);
        chk("grant_count1 pre", 32'(grant_count[16 +: 16]), 32'd2);
        chk("grant_count2 pre", 32'(grant_count[32 +: 16]), 32'd4);
        chk("grant_count3 pre", 32'(grant_count[48 +: 16]), 32'd4);
`endif
        drive(1, 4'b0010, 32'h10, 32'h20, 32'h30, 32'h40);
        rst = 1'b1;
        #1 check_outs("midrst", 4'b0000, 0, 32'h0, 4'b0000, 32'h0, 0);
`ifdef FOO_PIPELINE_ARBITER_STATS_EN
        for (int r = 0; r < 4; r++) chk($sformatf("grant_count%0d rst", r), 32'(grant_count[r*16 +: 16]), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        drive(0, 4'b0000, 32'h10, 32'h20, 32'h30, 32'h40);
        for (int c = 0; c < 3; c++) begin
            #1 check_outs($sformatf("postrst%0d", c), 4'b0000, 0, 32'h0, 4'b0000, 32'h0, 0);
            @(negedge clk);
        end
        drive(1, 4'b1111, 32'h10, 32'h20, 32'h30, 32'h40);
        #1 check_outs("postrst_idle", 4'b0000, 0, 32'h0, 4'b0000, 32'h0, 0);
        @(negedge clk);
        #1 check_outs("postrst_ptr0", 4'b0001, 1, 32'h10, 4'b0000, 32'h0, 1);
        @(negedge clk);
        drive(0, 4'b0000, 32'h10, 32'h20, 32'h30, 32'h40);
        #1 check_outs("postrst_resp", 4'b0000, 0, 32'h0, 4'b0001, 32'h11, 1);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
